lif_spike_rate_decoder: RTL and testbench

- Receive-side counterpart of the LIF neuron: consumes the 1-bit spike train the neuron emits and decodes it back into an 8-bit firing-rate value.
- Counts spikes over fixed windows of 2^WINDOW_LOG2 clock cycles.
- Hands each window's count to a downstream consumer over a valid/ready register.
- Sits between the neuron's spike output and the readout/uo_out mux in the tile.

---
 rtl/lif_spike_rate_decoder.sv | 85 ++++++++
 tb/tb_lif_spike_rate_decoder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/lif_spike_rate_decoder.sv
// lif_spike_rate_decoder: decodes a spike train into per-window spike counts behind a valid/ready register.
// Optional inter-spike-interval output enabled by defining LIF_DECODER_ISI_EN.
module lif_spike_rate_decoder #(
  parameter int WINDOW_LOG2 = 8,
  parameter int CNT_W       = 8,
  parameter int ISI_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ena,
  input  logic             i_spike_in,
  output logic [CNT_W-1:0] o_rate_out,
  output logic             o_rate_valid,
  input  logic             i_rate_ready,
  output logic             o_overrun,
  output logic             o_window_tick,
  output logic [ISI_W-1:0] o_isi_out,
  output logic             o_isi_valid
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t r_state, w_next;
  logic [WINDOW_LOG2-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_spike_cnt, w_cnt_inc, r_rate_out;
  logic r_rate_valid, r_overrun, r_window_tick;
  logic w_counting, w_close;
  always_comb begin
    w_next     = i_ena ? COUNT : IDLE;
    w_counting = (r_state == COUNT) && i_ena;
    w_close    = w_counting && (&r_win_cnt);
    w_cnt_inc  = r_spike_cnt + CNT_W'(i_spike_in && !(&r_spike_cnt));
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_win_cnt     <= '0;
      r_spike_cnt   <= '0;
      r_rate_out    <= '0;
      r_rate_valid  <= 1'b0;
      r_overrun     <= 1'b0;
      r_window_tick <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_win_cnt     <= w_counting ? r_win_cnt + 1'b1 : '0;
      r_spike_cnt   <= (w_counting && !w_close) ? w_cnt_inc : '0;
      r_window_tick <= w_close;
      // A closing window either loads the register (free or being drained) or is dropped
      if (w_close && (!r_rate_valid || i_rate_ready)) begin
        r_rate_out   <= w_cnt_inc;
        r_rate_valid <= 1'b1;
      end else if (w_close) begin
        r_overrun <= 1'b1;
      end else if (i_rate_ready) begin
        r_rate_valid <= 1'b0;
      end
    end
  end
  assign o_rate_out    = r_rate_out;
  assign o_rate_valid  = r_rate_valid;
  assign o_overrun     = r_overrun;
  assign o_window_tick = r_window_tick;
`ifdef LIF_DECODER_ISI_EN
  logic [ISI_W-1:0] r_gap, r_isi_out;
  logic r_armed, r_isi_valid, w_isi_hit;
  assign w_isi_hit = w_counting && i_spike_in && r_armed;
  // r_gap restarts at 1 on a spike so it reads directly as the interval at the next spike
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_gap       <= '0;
      r_isi_out   <= '0;
      r_armed     <= 1'b0;
      r_isi_valid <= 1'b0;
    end else begin
      r_isi_valid <= w_isi_hit;
      if (w_isi_hit) r_isi_out <= r_gap;
      r_armed <= w_counting && (r_armed || i_spike_in);
      r_gap   <= (w_counting && i_spike_in) ? ISI_W'(1) : ((&r_gap) ? r_gap : r_gap + 1'b1);
    end
  end
  assign o_isi_out   = r_isi_out;
  assign o_isi_valid = r_isi_valid;
`else
  assign o_isi_out   = '0;
  assign o_isi_valid = 1'b0;
`endif
endmodule

// File: tb/tb_lif_spike_rate_decoder.sv
// tb_lif_spike_rate_decoder: directed checks of windowing, saturation, handshake, overrun, ena drop, reset and ISI.
module tb_lif_spike_rate_decoder;
  logic clk = 1'b0;
  logic rst_n, ena, spike_in, rate_ready;
  logic [3:0] rate_out;
  logic rate_valid, overrun, window_tick;
  logic [7:0] isi_out;
  logic isi_valid;
  int checks = 0;
  int failures = 0;
  logic v0, t0;
  logic [3:0] r0;
  lif_spike_rate_decoder #(.WINDOW_LOG2(4), .CNT_W(4), .ISI_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_spike_in(spike_in),
    .o_rate_out(rate_out), .o_rate_valid(rate_valid), .i_rate_ready(rate_ready),
    .o_overrun(overrun), .o_window_tick(window_tick),
    .o_isi_out(isi_out), .o_isi_valid(isi_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic sp);
    spike_in = sp;
    @(posedge clk);
    #1;
  endtask
  task automatic window(input logic [15:0] p, input logic rf, input logic rm, input logic rl);
    for (int k = 0; k < 16; k++) begin
      rate_ready = (k == 0) ? rf : ((k == 15) ? rl : rm);
      tick(p[k]);
      if (k == 0) begin
        v0 = rate_valid;
        t0 = window_tick;
        r0 = rate_out;
      end
      if (k == 14) chk("no_early_tick", window_tick, 0);
    end
  endtask
  initial begin
    rst_n = 1'b0; ena = 1'b0; spike_in = 1'b0; rate_ready = 1'b0;
    tick(0); tick(0);
    chk("rst_rate_out", rate_out, 0);
    chk("rst_rate_valid", rate_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_window_tick", window_tick, 0);
    chk("rst_isi_out", isi_out, 0);
    chk("rst_isi_valid", isi_valid, 0);
    rst_n = 1'b1; ena = 1'b1; rate_ready = 1'b1;
    tick(0);
    window(16'h8492, 1, 1, 1);
    chk("w1_tick", window_tick, 1);
    chk("w1_rate", rate_out, 5);
    chk("w1_valid", rate_valid, 1);
    window(16'hFFFF, 1, 0, 1);
    chk("w1_xfer_valid", v0, 0);
    chk("w1_tick_one_cycle", t0, 0);
    chk("sat_rate", rate_out, 15);
    chk("sat_valid", rate_valid, 1);
    window(16'h0FC0, 0, 0, 1);
    chk("hold_valid", v0, 1);
    chk("hold_rate", r0, 15);
    chk("simul_rate", rate_out, 6);
    chk("simul_valid", rate_valid, 1);
    chk("simul_overrun", overrun, 0);
    window(16'h0111, 1, 0, 0);
    chk("w4_xfer_valid", v0, 0);
    chk("w4_rate", rate_out, 3);
    chk("w4_overrun", overrun, 0);
    window(16'h7F00, 0, 0, 0);
    chk("ovr_rate_kept", rate_out, 3);
    chk("ovr_valid", rate_valid, 1);
    chk("ovr_flag", overrun, 1);
    rate_ready = 1'b1;
    tick(1);
    chk("ovr_xfer_valid", rate_valid, 0);
    chk("ovr_xfer_rate", rate_out, 3);
    tick(0); tick(1); tick(0); tick(1); tick(0); tick(1); tick(0);
    ena = 1'b0;
    tick(1); tick(1); tick(1);
    chk("ena_off_valid", rate_valid, 0);
    chk("ena_off_tick", window_tick, 0);
    chk("ena_off_overrun", overrun, 1);
    ena = 1'b1;
    tick(0);
    window(16'h0210, 1, 1, 1);
    chk("reena_tick", window_tick, 1);
    chk("reena_rate", rate_out, 2);
    chk("reena_valid", rate_valid, 1);
    rate_ready = 1'b0;
    tick(1); tick(1); tick(0);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_rate", rate_out, 0);
    chk("mid_rst_valid", rate_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_tick", window_tick, 0);
    rst_n = 1'b1;
    tick(0);
    tick(0);
    tick(1);
`ifdef LIF_DECODER_ISI_EN
    chk("isi_first_no_pulse", isi_valid, 0);
    tick(1);
    chk("isi1_valid", isi_valid, 1);
    chk("isi1_out", isi_out, 1);
    tick(0);
    chk("isi1_pulse_end", isi_valid, 0);
    chk("isi1_hold", isi_out, 1);
    tick(0); tick(0); tick(0); tick(0);
    tick(1);
    chk("isi2_valid", isi_valid, 1);
    chk("isi2_out", isi_out, 6);
    tick(0);
    chk("isi2_pulse_end", isi_valid, 0);
`else
    tick(1);
    chk("isi_off_out", isi_out, 0);
    chk("isi_off_valid", isi_valid, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
